// File: rtl/election_pkg.sv
// Shared phase, mode and status definitions for the avatar-election controller.
package election_pkg;

    typedef enum logic [1:0] {
        PH_REGISTER = 2'd0,
        PH_VOTE     = 2'd1,
        PH_TALLY    = 2'd2,
        PH_DONE     = 2'd3
    } phase_e;

    localparam logic [1:0] MODE_REGISTER = 2'b00;
    localparam logic [1:0] MODE_VOTE     = 2'b01;

    typedef logic [3:0] status_t;

    localparam status_t ST_OK                 = 4'd0;
    localparam status_t ST_ALREADY_REGISTERED = 4'd1;
    localparam status_t ST_ALREADY_VOTED      = 4'd2;
    localparam status_t ST_NOT_REGISTERED     = 4'd3;
    localparam status_t ST_VOTING_NOT_STARTED = 4'd4;
    localparam status_t ST_REGISTRATION_ENDED = 4'd5;
    localparam status_t ST_CLOSED             = 4'd6;
    localparam status_t ST_BAD_MODE           = 4'd7;
    localparam status_t ST_WRONG_BOX          = 4'd8;

    localparam int unsigned TALLY_LEN = 4;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter: combinational one-hot grant, pointer
// advances past the granted requester on every grant.
module rr_arbiter4 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_valid_o
);

    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!gnt_valid_o && req_i[ptr_q + 2'(k)]) begin
                gnt_valid_o               = 1'b1;
                gnt_idx_o                 = ptr_q + 2'(k);
                gnt_o[ptr_q + 2'(k)]      = 1'b1;
            end
        end
        ptr_d = gnt_valid_o ? gnt_idx_o + 2'd1 : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/election_controller.sv
// Election sequencer: phase timer, voter tables, tally FSM and response register.
// Optional macro BOX_CHECK_EN: reject requests whose userID[5:4] differs from the box index.
module election_controller
    import election_pkg::*;
#(
    parameter int REG_CYCLES  = 100,
    parameter int VOTE_CYCLES = 100
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  req_valid,
    input  logic [7:0]  req_mode,
    input  logic [23:0] req_user,
    input  logic [7:0]  req_cand,
    output logic [3:0]  req_ready,
    output logic        resp_valid,
    output logic [1:0]  resp_box,
    output logic [5:0]  resp_user,
    output logic [3:0]  resp_status,
    output logic [1:0]  phase,
    output logic [6:0]  num_registered,
    output logic        winner_valid,
    output logic [1:0]  winner_id,
    output logic [6:0]  winner_votes
);

    localparam int MAXC = (REG_CYCLES > VOTE_CYCLES) ? REG_CYCLES : VOTE_CYCLES;
    localparam int TW   = ($clog2(MAXC) > 2) ? $clog2(MAXC) : 2;

    phase_e          phase_q, phase_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [63:0]     reg_q, reg_d, voted_q, voted_d;
    logic [3:0][6:0] votes_q, votes_d;
    logic [6:0]      nreg_q, nreg_d, best_q, best_d;
    logic [1:0]      win_id_q, win_id_d;
    logic            rv_q;
    logic [1:0]      rbox_q;
    logic [5:0]      ruser_q;
    status_t         rst_q, st;

    logic [1:0] gidx;
    logic       gvalid;
    logic [1:0] mode_a [4];
    logic [5:0] user_a [4];
    logic [1:0] cand_a [4];
    logic [1:0] sel_mode, sel_cand;
    logic [5:0] sel_user;

    rr_arbiter4 u_arb (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .req_i       (req_valid),
        .gnt_o       (req_ready),
        .gnt_idx_o   (gidx),
        .gnt_valid_o (gvalid)
    );

    for (genvar b = 0; b < 4; b++) begin : g_unpack
        assign mode_a[b] = req_mode[2*b +: 2];
        assign user_a[b] = req_user[6*b +: 6];
        assign cand_a[b] = req_cand[2*b +: 2];
    end

    assign sel_mode = mode_a[gidx];
    assign sel_user = user_a[gidx];
    assign sel_cand = cand_a[gidx];

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        reg_d    = reg_q;
        voted_d  = voted_q;
        votes_d  = votes_q;
        nreg_d   = nreg_q;
        best_d   = best_q;
        win_id_d = win_id_q;
        st       = ST_OK;

        // cnt_q doubles as the tally index while in TALLY
        case (phase_q)
            PH_REGISTER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TW'(REG_CYCLES - 1)) begin
                    phase_d = PH_VOTE;
                    cnt_d   = '0;
                end
            end
            PH_VOTE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TW'(VOTE_CYCLES - 1)) begin
                    phase_d = PH_TALLY;
                    cnt_d   = '0;
                end
            end
            PH_TALLY: begin
                cnt_d = cnt_q + 1'b1;
                if (votes_q[cnt_q[1:0]] > best_q) begin
                    best_d   = votes_q[cnt_q[1:0]];
                    win_id_d = cnt_q[1:0];
                end
                if (cnt_q == TW'(TALLY_LEN - 1)) phase_d = PH_DONE;
            end
            default: cnt_d = cnt_q;
        endcase

        if (gvalid) begin
            if (sel_mode[1]) begin
                st = ST_BAD_MODE;
            end
`ifdef BOX_CHECK_EN
            else if (sel_user[5:4] != gidx) begin
                st = ST_WRONG_BOX;
            end
`endif
            else begin
                case (phase_q)
                    PH_REGISTER: begin
                        if (sel_mode != MODE_REGISTER) begin
                            st = ST_VOTING_NOT_STARTED;
                        end else if (reg_q[sel_user]) begin
                            st = ST_ALREADY_REGISTERED;
                        end else begin
                            reg_d[sel_user] = 1'b1;
                            nreg_d          = nreg_q + 7'd1;
                        end
                    end
                    PH_VOTE: begin
                        if (sel_mode != MODE_VOTE) begin
                            st = ST_REGISTRATION_ENDED;
                        end else if (!reg_q[sel_user]) begin
                            st = ST_NOT_REGISTERED;
                        end else if (voted_q[sel_user]) begin
                            st = ST_ALREADY_VOTED;
                        end else begin
                            voted_d[sel_user] = 1'b1;
                            votes_d[sel_cand] = votes_q[sel_cand] + 7'd1;
                        end
                    end
                    default: st = ST_CLOSED;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q  <= PH_REGISTER;
            cnt_q    <= '0;
            reg_q    <= '0;
            voted_q  <= '0;
            votes_q  <= '0;
            nreg_q   <= '0;
            best_q   <= '0;
            win_id_q <= '0;
            rv_q     <= 1'b0;
            rbox_q   <= '0;
            ruser_q  <= '0;
            rst_q    <= ST_OK;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            reg_q    <= reg_d;
            voted_q  <= voted_d;
            votes_q  <= votes_d;
            nreg_q   <= nreg_d;
            best_q   <= best_d;
            win_id_q <= win_id_d;
            rv_q     <= gvalid;
            if (gvalid) begin
                rbox_q  <= gidx;
                ruser_q <= sel_user;
                rst_q   <= st;
            end
        end
    end

    assign resp_valid     = rv_q;
    assign resp_box       = rbox_q;
    assign resp_user      = ruser_q;
    assign resp_status    = rst_q;
    assign phase          = phase_q;
    assign num_registered = nreg_q;
    assign winner_valid   = (phase_q == PH_DONE);
    assign winner_id      = win_id_q;
    assign winner_votes   = best_q;

endmodule

// File: tb/tb_election_controller.sv
// Bench for election_controller: directed election scenarios plus randomized
// traffic, checked against a table-level model of the election rules.
module tb_election_controller;

    localparam int R = 20;
    localparam int V = 20;

    localparam logic [3:0] S_OK    = 4'd0;
    localparam logic [3:0] S_AREG  = 4'd1;
    localparam logic [3:0] S_AVOTE = 4'd2;
    localparam logic [3:0] S_NREG  = 4'd3;
    localparam logic [3:0] S_VNS   = 4'd4;
    localparam logic [3:0] S_RENDED= 4'd5;
    localparam logic [3:0] S_CLOSED= 4'd6;
    localparam logic [3:0] S_BAD   = 4'd7;
    localparam logic [3:0] S_WBOX  = 4'd8;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [3:0]      req_valid;
    logic [3:0][1:0] mode_a;
    logic [3:0][5:0] user_a;
    logic [3:0][1:0] cand_a;
    logic [3:0]      req_ready;
    logic            resp_valid;
    logic [1:0]      resp_box;
    logic [5:0]      resp_user;
    logic [3:0]      resp_status;
    logic [1:0]      phase;
    logic [6:0]      num_registered;
    logic            winner_valid;
    logic [1:0]      winner_id;
    logic [6:0]      winner_votes;

    always #5 CLK = ~CLK;

    election_controller #(.REG_CYCLES(R), .VOTE_CYCLES(V)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .req_valid      (req_valid),
        .req_mode       (mode_a),
        .req_user       (user_a),
        .req_cand       (cand_a),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_box       (resp_box),
        .resp_user      (resp_user),
        .resp_status    (resp_status),
        .phase          (phase),
        .num_registered (num_registered),
        .winner_valid   (winner_valid),
        .winner_id      (winner_id),
        .winner_votes   (winner_votes)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Election model: plain tables indexed by userID and candidate.
    bit m_reg [64];
    bit m_voted [64];
    int m_votes [4];
    int m_nreg, m_ptr, m_cyc;
    bit e_rv;
    int e_box, e_user;
    logic [3:0] e_st;

    function automatic int phase_of(input int c);
        if (c < R)         return 0;
        if (c < R + V)     return 1;
        if (c < R + V + 4) return 2;
        return 3;
    endfunction

    function automatic logic [3:0] model_status(input int b);
        int u;
        int ph;
        u  = int'(user_a[b]);
        ph = phase_of(m_cyc);
        if (mode_a[b][1]) return S_BAD;
`ifdef BOX_CHECK_EN
        if (u / 16 != b) return S_WBOX;
`endif
        if (ph >= 2) return S_CLOSED;
        if (ph == 0) begin
            if (mode_a[b] == 2'b01) return S_VNS;
            if (m_reg[u]) return S_AREG;
            m_reg[u] = 1'b1;
            m_nreg++;
            return S_OK;
        end
        if (mode_a[b] == 2'b00) return S_RENDED;
        if (!m_reg[u]) return S_NREG;
        if (m_voted[u]) return S_AVOTE;
        m_voted[u] = 1'b1;
        m_votes[int'(cand_a[b])]++;
        return S_OK;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_reg[i]   = 1'b0;
            m_voted[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) m_votes[i] = 0;
        m_nreg = 0;
        m_ptr  = 0;
        m_cyc  = 0;
    endtask

    task automatic idle();
        req_valid = '0;
        mode_a    = '0;
        user_a    = '0;
        cand_a    = '0;
    endtask

    task automatic set_req(input int b, input logic [1:0] mode, input logic [5:0] user, input logic [1:0] cand);
        req_valid[b] = 1'b1;
        mode_a[b]    = mode;
        user_a[b]    = user;
        cand_a[b]    = cand;
    endtask

    task automatic rand_req(input bit allow_vote);
        req_valid = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) begin
            int r;
            logic [5:0] u;
            r = int'($urandom_range(0, 7));
            if (r < 3)       mode_a[b] = 2'b00;
            else if (r < 6)  mode_a[b] = 2'b01;
            else if (r == 6) mode_a[b] = 2'b10;
            else             mode_a[b] = 2'b11;
            if (!allow_vote && mode_a[b] == 2'b01) mode_a[b] = 2'b00;
            u = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) u[5:4] = 2'(b);
            if (u == 6'd9 || u == 6'd40 || u == 6'd48) u = u + 6'd1;
            user_a[b] = u;
            cand_a[b] = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_resp_status"}, 32'(resp_status), 32'd0);
        check_eq({tag, "_phase"}, 32'(phase), 32'd0);
        check_eq({tag, "_num_registered"}, 32'(num_registered), 32'd0);
        check_eq({tag, "_winner_valid"}, 32'(winner_valid), 32'd0);
        check_eq({tag, "_winner_votes"}, 32'(winner_votes), 32'd0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        idle();
        model_clear();
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RST_N = 1'b1;
    endtask

    // One clock: check the grant, advance the model, then check registered outputs.
    task automatic step();
        int g;
        int best, bid;
        logic [3:0] exp_gnt;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        exp_gnt = (g < 0) ? 4'b0000 : 4'(1 << g);
        check_eq("req_ready", 32'(req_ready), 32'(exp_gnt));
        e_rv = 1'b0;
        if (g >= 0) begin
            e_rv   = 1'b1;
            e_box  = g;
            e_user = int'(user_a[g]);
            e_st   = model_status(g);
            m_ptr  = (g + 1) % 4;
        end
        @(posedge CLK);
        #1;
        m_cyc++;
        check_eq("resp_valid", 32'(resp_valid), 32'(e_rv));
        if (e_rv) begin
            check_eq("resp_box", 32'(resp_box), e_box);
            check_eq("resp_user", 32'(resp_user), e_user);
            check_eq("resp_status", 32'(resp_status), 32'(e_st));
        end
        check_eq("phase", 32'(phase), phase_of(m_cyc));
        check_eq("num_registered", 32'(num_registered), m_nreg);
        check_eq("winner_valid", 32'(winner_valid), 32'(phase_of(m_cyc) == 3));
        if (phase_of(m_cyc) == 3) begin
            best = 0;
            bid  = 0;
            for (int i = 0; i < 4; i++)
                if (m_votes[i] > best) begin
                    best = m_votes[i];
                    bid  = i;
                end
            check_eq("winner_id", 32'(winner_id), bid);
            check_eq("winner_votes", 32'(winner_votes), best);
        end
    endtask

    initial begin
        idle();
        model_clear();
        #2;
        check_reset_outputs("por");

        // ---------------- run 1: directed election ----------------
        do_reset();
        step(); step();
        idle(); set_req(0, 2'b00, 6'd5, 2'd0); step();
        check_eq("tp_reg_u5", 32'(resp_status), 32'(S_OK));
        idle(); set_req(1, 2'b00, 6'd5, 2'd0); step();
`ifdef BOX_CHECK_EN
        check_eq("tp_rereg_u5", 32'(resp_status), 32'(S_WBOX));
`else
        check_eq("tp_rereg_u5", 32'(resp_status), 32'(S_AREG));
`endif
        check_eq("tp_nreg_one", 32'(num_registered), 32'd1);
        idle(); set_req(3, 2'b00, 6'd50, 2'd0); step();
        idle(); set_req(0, 2'b01, 6'd9, 2'd0); step();
        check_eq("tp_vote_early", 32'(resp_status), 32'(S_VNS));
        idle(); set_req(1, 2'b00, 6'd17, 2'd0); step();
        idle(); set_req(2, 2'b00, 6'd33, 2'd0); step();
        idle(); set_req(3, 2'b00, 6'd49, 2'd0); step();
        idle();
        for (int b = 0; b < 4; b++) set_req(b, 2'b00, 6'(16 * b + 10), 2'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("tp_rr_order", 32'(resp_box), k);
        end
        idle(); set_req(0, 2'b00, 6'h30, 2'd0); step();
`ifdef BOX_CHECK_EN
        check_eq("tp_box_check", 32'(resp_status), 32'(S_WBOX));
`else
        check_eq("tp_box_check", 32'(resp_status), 32'(S_OK));
`endif
        idle(); set_req(1, 2'b11, 6'h11, 2'd0); step();
        check_eq("tp_bad_mode", 32'(resp_status), 32'(S_BAD));
        while (m_cyc < R - 1) begin
            rand_req(1'b1);
            step();
        end
        idle(); set_req(0, 2'b00, 6'd9, 2'd0); step();
        check_eq("tp_reg_last_cycle", 32'(resp_status), 32'(S_OK));
        idle(); set_req(0, 2'b01, 6'd9, 2'd2); step();
        check_eq("tp_vote_first_cycle", 32'(resp_status), 32'(S_OK));
        idle(); set_req(0, 2'b01, 6'd9, 2'd2); step();
        check_eq("tp_vote_twice", 32'(resp_status), 32'(S_AVOTE));
        idle(); set_req(2, 2'b01, 6'd40, 2'd0); step();
        check_eq("tp_vote_unreg", 32'(resp_status), 32'(S_NREG));
        idle(); set_req(0, 2'b01, 6'd5, 2'd2); step();
        idle(); set_req(1, 2'b01, 6'd17, 2'd1); step();
        idle(); set_req(2, 2'b01, 6'd33, 2'd1); step();
        while (m_cyc < R + V + 4) begin
            rand_req(1'b0);
            step();
        end
        check_eq("tp_done_phase", 32'(phase), 32'd3);
        check_eq("tp_done_valid", 32'(winner_valid), 32'd1);
        check_eq("tp_tie_id", 32'(winner_id), 32'd1);
        check_eq("tp_tie_votes", 32'(winner_votes), 32'd2);
        repeat (5) begin
            rand_req(1'b1);
            step();
        end

        // ---------------- run 2: reset mid-VOTE with a response pending ----------------
        do_reset();
        while (m_cyc < R + 5) begin
            rand_req(1'b1);
            step();
        end
        idle(); set_req(0, 2'b00, 6'd3, 2'd0); step();
        check_eq("tp_pending_resp", 32'(resp_valid), 32'd1);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midreset");

        // ---------------- run 3: full randomized election ----------------
        do_reset();
        idle(); set_req(0, 2'b00, 6'd9, 2'd0); step();
        check_eq("tp_rereg_after_reset", 32'(resp_status), 32'(S_OK));
        while (m_cyc < R + V + 8) begin
            rand_req(1'b1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
